serial_word_feeder: RTL



---
 rtl/serial_word_feeder.sv | 94 +++++++++
 1 files changed

// File: rtl/serial_word_feeder.sv
// Serializes valid/ready parallel words MSB-first, one bit per clock, with a one-entry
// hold buffer for gapless back-to-back frames. Define SER_PARITY_EN to append even parity.
module serial_word_feeder #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] word_in,
  input  logic             word_valid,
  output logic             word_ready,
  output logic             data_out,
  output logic             bit_valid,
  output logic             frame_start,
  output logic             busy
);

`ifdef SER_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int            CW   = $clog2(FLEN);
  localparam logic [CW-1:0] LAST = CW'(FLEN - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]      r_state;
  logic [FLEN-1:0] r_sr;
  logic [FLEN-1:0] r_hb;
  logic            r_hb_full;
  logic [CW-1:0]   r_cnt;

  logic [FLEN-1:0] w_load;
  logic            w_accept;
  logic            w_last;
  logic            w_hb_load;

  // The parity bit travels with the word as the frame's trailing bit.
`ifdef SER_PARITY_EN
  assign w_load = {word_in, ^word_in};
`else
  assign w_load = word_in;
`endif

  assign word_ready  = !r_hb_full;
  assign w_accept    = word_valid && !r_hb_full;
  assign w_last      = (r_cnt == LAST);
  assign w_hb_load   = w_accept && (r_state == SHIFT) && !w_last;

  assign data_out    = (r_state == SHIFT) ? r_sr[FLEN-1] : IDLE_BIT;
  assign bit_valid   = (r_state == SHIFT);
  assign frame_start = (r_state == SHIFT) && (r_cnt == '0);
  assign busy        = (r_state == SHIFT) || r_hb_full;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_sr      <= '0;
      r_cnt     <= '0;
      r_hb_full <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_accept) begin
        r_sr    <= w_load;
        r_cnt   <= '0;
        r_state <= SHIFT;
      end
    end else if (w_last) begin
      r_cnt <= '0;
      if (r_hb_full) begin
        r_sr      <= r_hb;
        r_hb_full <= 1'b0;
      end else if (w_accept) begin
        r_sr <= w_load;
      end else begin
        r_state <= IDLE;
      end
    end else begin
      r_sr  <= {r_sr[FLEN-2:0], 1'b0};
      r_cnt <= r_cnt + CW'(1);
      if (w_accept) r_hb_full <= 1'b1;
    end
  end

  // NOTE: the hold payload is left out of reset; r_hb_full alone says whether it
  // is meaningful, so a reset discards the held word without clearing the data.
  always_ff @(posedge clock) begin
    if (w_hb_load) r_hb <= w_load;
  end

endmodule
